// File: rtl/pixel_controller.sv
// Moves pixel windows between the 24-bit SRAM and the edge-detector buffer:
// reads RGB words into a grayscale buffer, then writes pixels back as replicated RGB.
//
// state   | meaning
// S_IDLE  | waiting for i_enable; snapshots offsets, counts and pixels on start
// S_READ  | read strobe on rd_off+idx for ACCESS_CYCLES clocks per pixel
// S_WRITE | write strobe on wr_off+idx with {p,p,p} for ACCESS_CYCLES clocks per pixel
// S_DONE  | one-cycle completion pulse
module pixel_controller #(
  parameter int ADDR_BITS     = 16,
  parameter int NUM_PIX       = 20,
  parameter int ACCESS_CYCLES = 2
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_enable,
  input  logic [NUM_PIX-1:0][7:0]  i_data_in,
  input  logic [ADDR_BITS-1:0]     i_address_read_offset,
  input  logic [ADDR_BITS-1:0]     i_address_write_offset,
  input  logic [4:0]               i_num_pix_read,
  input  logic [4:0]               i_num_pix_write,
  input  logic [23:0]              i_r_data,
  output logic [NUM_PIX-1:0][7:0]  o_data_out,
  output logic [ADDR_BITS-1:0]     o_address,
  output logic [23:0]              o_w_data,
  output logic                     o_read_enable,
  output logic                     o_write_enable,
  output logic                     o_done
);

  localparam int              CYC_W    = $clog2(ACCESS_CYCLES);
  localparam logic [CYC_W-1:0] CYC_LOAD = CYC_W'(ACCESS_CYCLES - 1);
  localparam logic [4:0]      MAX_PIX  = 5'(NUM_PIX);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_DONE} state_t;

  state_t                    r_state;
  state_t                    w_next;
  logic [NUM_PIX-1:0][7:0]   r_data_out;
  logic [NUM_PIX-1:0][7:0]   r_snap;
  logic [ADDR_BITS-1:0]      r_rd_off;
  logic [ADDR_BITS-1:0]      r_wr_off;
  logic [4:0]                r_nrd;
  logic [4:0]                r_nwr;
  logic [4:0]                r_idx;
  logic [CYC_W-1:0]          r_cyc;

  logic [4:0]                w_nrd_clamp;
  logic [4:0]                w_nwr_clamp;
  logic                      w_last;
  logic                      w_rd_end;
  logic                      w_wr_end;
  logic [ADDR_BITS-1:0]      w_idx_ext;
  logic [7:0]                w_pix;
  logic [9:0]                w_sum;
  logic [7:0]                w_gray;

  assign w_nrd_clamp = (i_num_pix_read  > MAX_PIX) ? MAX_PIX : i_num_pix_read;
  assign w_nwr_clamp = (i_num_pix_write > MAX_PIX) ? MAX_PIX : i_num_pix_write;
  assign w_last      = (r_cyc == '0);
  assign w_rd_end    = w_last && (r_idx == r_nrd - 5'd1);
  assign w_wr_end    = w_last && (r_idx == r_nwr - 5'd1);
  assign w_idx_ext   = ADDR_BITS'(r_idx);
  assign w_pix       = r_snap[r_idx];
  // R + 2G + B fits in 10 bits, so the >>2 can never lose a carry
  assign w_sum       = 10'(i_r_data[23:16]) + {1'b0, i_r_data[15:8], 1'b0} + 10'(i_r_data[7:0]);
  assign w_gray      = w_sum[9:2];
  assign o_data_out  = r_data_out;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next         = r_state;
    o_address      = '0;
    o_w_data       = '0;
    o_read_enable  = 1'b0;
    o_write_enable = 1'b0;
    o_done         = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (i_enable) begin
          if (w_nrd_clamp != 5'd0)      w_next = S_READ;
          else if (w_nwr_clamp != 5'd0) w_next = S_WRITE;
          else                          w_next = S_DONE;
        end
      end
      S_READ: begin
        o_read_enable = 1'b1;
        o_address     = r_rd_off + w_idx_ext;
        if (w_rd_end) w_next = (r_nwr != 5'd0) ? S_WRITE : S_DONE;
      end
      S_WRITE: begin
        o_write_enable = 1'b1;
        o_address      = r_wr_off + w_idx_ext;
        o_w_data       = {w_pix, w_pix, w_pix};
        if (w_wr_end) w_next = S_DONE;
      end
      S_DONE: begin
        o_done = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // r_cyc counts down each pixel's access window; terminal count marks its last clock
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_data_out <= '0;
      r_snap     <= '0;
      r_rd_off   <= '0;
      r_wr_off   <= '0;
      r_nrd      <= '0;
      r_nwr      <= '0;
      r_idx      <= '0;
      r_cyc      <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (i_enable) begin
            r_snap   <= i_data_in;
            r_rd_off <= i_address_read_offset;
            r_wr_off <= i_address_write_offset;
            r_nrd    <= w_nrd_clamp;
            r_nwr    <= w_nwr_clamp;
            r_idx    <= '0;
            r_cyc    <= CYC_LOAD;
          end
        end
        S_READ: begin
          if (w_last) begin
            r_data_out[r_idx] <= w_gray;
            r_cyc             <= CYC_LOAD;
            r_idx             <= w_rd_end ? 5'd0 : r_idx + 5'd1;
          end else begin
            r_cyc <= r_cyc - CYC_W'(1);
          end
        end
        S_WRITE: begin
          if (w_last) begin
            r_cyc <= CYC_LOAD;
            r_idx <= r_idx + 5'd1;
          end else begin
            r_cyc <= r_cyc - CYC_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_controller.sv
// Directed bench for pixel_controller: an SRAM model, a scoreboard of expected
// bus accesses, and a gray-buffer model checked after every transaction.
module tb_pixel_controller;

  localparam int AC = 2;

  typedef struct packed {
    logic        we;
    logic [15:0] addr;
    logic [23:0] wd;
  } acc_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             enable;
  logic [19:0][7:0] data_in;
  logic [15:0]      rd_off, wr_off;
  logic [4:0]       nrd, nwr;
  logic [23:0]      r_data;
  logic [19:0][7:0] data_out;
  logic [15:0]      address;
  logic [23:0]      w_data;
  logic             read_enable, write_enable, done;

  logic [23:0]      mem [0:65535];
  logic [19:0][7:0] ref_out;
  acc_t             exp_q[$];
  int               n_checks = 0;
  int               n_fail   = 0;

  pixel_controller dut (
    .i_clk(clk), .i_rst(rst), .i_enable(enable), .i_data_in(data_in),
    .i_address_read_offset(rd_off), .i_address_write_offset(wr_off),
    .i_num_pix_read(nrd), .i_num_pix_write(nwr), .i_r_data(r_data),
    .o_data_out(data_out), .o_address(address), .o_w_data(w_data),
    .o_read_enable(read_enable), .o_write_enable(write_enable), .o_done(done)
  );

  always #5 clk = ~clk;

  assign r_data = mem[address];

  task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] gray(input logic [23:0] w);
    int s;
    s = int'(w[23:16]) + 2 * int'(w[15:8]) + int'(w[7:0]);
    return 8'(s / 4);
  endfunction

  // SRAM model plus scoreboard pop: one entry per strobed clock
  always @(negedge clk) begin
    acc_t e, o;
    if (!rst && (read_enable || write_enable)) begin
      check("strobe_exclusive", {159'b0, read_enable & write_enable}, 160'b0);
      o.we   = write_enable;
      o.addr = address;
      o.wd   = write_enable ? w_data : 24'h0;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $error("FAIL unexpected_access observed=%0h expected=none", o);
      end else begin
        e = exp_q.pop_front();
        check("bus_access", 160'(o), 160'(e));
      end
      if (write_enable) mem[address] = w_data;
    end
  end

  task automatic push_expected(input logic [15:0] ro, wo, input int nrc, nwc);
    acc_t a;
    for (int i = 0; i < nrc; i++) begin
      ref_out[i] = gray(mem[ro + 16'(i)]);
      a.we = 1'b0; a.addr = ro + 16'(i); a.wd = 24'h0;
      for (int k = 0; k < AC; k++) exp_q.push_back(a);
    end
    for (int j = 0; j < nwc; j++) begin
      a.we = 1'b1; a.addr = wo + 16'(j); a.wd = {data_in[j], data_in[j], data_in[j]};
      for (int k = 0; k < AC; k++) exp_q.push_back(a);
    end
  endtask

  task automatic run(input logic [15:0] ro, wo, input logic [4:0] nr, nw, input string tag);
    int nrc, nwc, lat, cnt;
    nrc = (nr > 5'd20) ? 20 : int'(nr);
    nwc = (nw > 5'd20) ? 20 : int'(nw);
    lat = AC * (nrc + nwc) + 2;
    push_expected(ro, wo, nrc, nwc);
    rd_off = ro; wr_off = wo; nrd = nr; nwr = nw; enable = 1'b1;
    @(posedge clk);
    @(negedge clk);
    enable = 1'b0;
    // scrambled inputs after the start sample must not leak into the transaction
    for (int i = 0; i < 20; i++) data_in[i] = 8'($urandom);
    rd_off = 16'($urandom); wr_off = 16'($urandom); nrd = 5'($urandom); nwr = 5'($urandom);
    cnt = 2;
    while (!done && cnt < 300) begin
      @(negedge clk);
      cnt++;
    end
    check({tag, "_latency"}, 160'(cnt), 160'(lat));
    check({tag, "_sb_drained"}, 160'(exp_q.size()), 160'(0));
    for (int i = 0; i < 20; i++)
      check($sformatf("%s_data_out[%0d]", tag, i), 160'(data_out[i]), 160'(ref_out[i]));
    @(negedge clk);
    check({tag, "_done_one_cycle"}, {159'b0, done}, 160'b0);
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; data_in = '0; rd_off = '0; wr_off = '0; nrd = '0; nwr = '0;
    ref_out = '0;
    for (int i = 0; i < 64; i++) mem[i] = 24'($urandom);
    for (int i = 0; i < 64; i++) mem[16'h3000 + i] = 24'($urandom);
    mem[0] = 24'hFF0000; mem[1] = 24'h00FF00; mem[2] = 24'h808080;
    mem[16'hFFFE] = 24'h102030; mem[16'hFFFF] = 24'hFFFFFF;
    #2;
    check("rst_address", 160'(address), 160'(0));
    check("rst_w_data", 160'(w_data), 160'(0));
    check("rst_strobes", 160'({read_enable, write_enable, done}), 160'(0));
    check("rst_data_out", 160'(data_out), 160'(0));
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // three reads with known gray results
    run(16'h0000, 16'h0000, 5'd3, 5'd0, "t1");
    check("t1_px0", 160'(data_out[0]), 160'(8'h3F));
    check("t1_px1", 160'(data_out[1]), 160'(8'h7F));
    check("t1_px2", 160'(data_out[2]), 160'(8'h80));

    // two writes, no reads
    data_in = '0; data_in[0] = 8'h12; data_in[1] = 8'hAB;
    run(16'h0000, 16'h0100, 5'd0, 5'd2, "t2");
    check("t2_mem100", 160'(mem[16'h0100]), 160'(24'h121212));
    check("t2_mem101", 160'(mem[16'h0101]), 160'(24'hABABAB));

    // full-depth read, then write the modelled gray values back
    run(16'h0000, 16'h0000, 5'd20, 5'd0, "t3r");
    data_in = ref_out;
    run(16'h0000, 16'h1000, 5'd0, 5'd20, "t3w");
    for (int i = 0; i < 20; i++)
      check($sformatf("t3_roundtrip[%0d]", i), 160'(mem[16'h1000 + i]),
            160'({ref_out[i], ref_out[i], ref_out[i]}));

    // address wrap across 0xFFFF
    run(16'hFFFE, 16'h0000, 5'd4, 5'd0, "t4");

    // empty transaction and over-range count clamp
    run(16'h0000, 16'h0000, 5'd0, 5'd0, "t5_empty");
    run(16'h3000, 16'h0000, 5'd31, 5'd0, "t5_clamp");

    // combined read + write
    for (int i = 0; i < 20; i++) data_in[i] = 8'($urandom);
    run(16'h3010, 16'h4000, 5'd5, 5'd7, "t_mixed");

    // reset during the write of pixel 5
    for (int j = 5; j < 10; j++) mem[16'h2000 + j] = 24'hDEAD00 + 24'(j);
    for (int i = 0; i < 20; i++) data_in[i] = 8'($urandom);
    push_expected(16'h0000, 16'h2000, 0, 5);
    rd_off = 16'h0000; wr_off = 16'h2000; nrd = 5'd0; nwr = 5'd10; enable = 1'b1;
    @(posedge clk);
    @(negedge clk);
    enable = 1'b0;
    repeat (9) @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("t6_rst_we", {159'b0, write_enable}, 160'b0);
    check("t6_rst_address", 160'(address), 160'(0));
    check("t6_rst_w_data", 160'(w_data), 160'(0));
    check("t6_rst_data_out", 160'(data_out), 160'(0));
    ref_out = '0;
    @(negedge clk); @(posedge clk); @(negedge clk);
    rst = 1'b0;
    check("t6_sb_drained", 160'(exp_q.size()), 160'(0));
    for (int j = 5; j < 10; j++)
      check($sformatf("t6_untouched[%0d]", j), 160'(mem[16'h2000 + j]), 160'(24'hDEAD00 + 24'(j)));
    @(negedge clk);

    // controller returns to a working IDLE after the abort
    run(16'h0000, 16'h0000, 5'd1, 5'd0, "t7_after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
